fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 157 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-granular round-robin arbiter in front of a single
// FIFO push port. A requester that wins arbitration owns the port until it
// presents its last beat. FIFO full stalls the owner without releasing the
// lock. A watchdog aborts a packet whose owner goes quiet for TIMEOUT cycles.
module fifo_wr_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                     wclk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     push,
    output logic [DWIDTH-1:0]        wdata,
    input  logic                     full,
    output logic [IDW-1:0]           owner,
    output logic                     busy,
    output logic                     err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    // The watchdog aborts on the edge that ends the TIMEOUT-th idle cycle.
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [IDW-1:0]      r_rr;
    logic [IDW-1:0]      w_rr_next;
    logic [IDW-1:0]      r_owner;
    logic [IDW-1:0]      w_owner_next;
    logic                r_err;
    logic                w_err_next;
    logic [7:0]          r_wdog;
    logic [7:0]          w_wdog_next;

    logic [DWIDTH-1:0]   w_data_arr [NREQ];
    logic                w_own_req;
    logic                w_own_last;
    logic                w_accept;
    logic                w_found_hi;
    logic                w_found_lo;
    logic [IDW-1:0]      w_win_hi;
    logic [IDW-1:0]      w_win_lo;
    logic [IDW-1:0]      w_winner;

    // Unpack the flat data bus and build the one-hot grant vector.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign w_data_arr[gi] = req_data[gi*DWIDTH +: DWIDTH];
            assign gnt[gi]        = w_accept && (r_owner == IDW'(gi));
        end
    endgenerate

    assign w_own_req  = req[r_owner];
    assign w_own_last = req_last[r_owner];
    // A beat moves only when locked, the owner is valid, the FIFO has room
    // and no reset is in progress.
    assign w_accept   = (r_state == ST_XFER) && w_own_req && !full && !reset;

    assign push  = |gnt;
    assign wdata = w_data_arr[r_owner];
    assign owner = r_owner;
    assign busy  = (r_state != ST_IDLE);
    assign err   = r_err;

    // Round-robin winner: lowest requester above the pointer, else the
    // lowest requester at or below it (wraparound).
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (IDW'(i) > r_rr) begin
                    w_found_hi = 1'b1;
                    w_win_hi   = IDW'(i);
                end else begin
                    w_found_lo = 1'b1;
                    w_win_lo   = IDW'(i);
                end
            end
        end
        w_winner = w_found_hi ? w_win_hi : w_win_lo;
    end

    // Next-state logic: arbitration, packet lock, stall and watchdog abort.
    always_comb begin
        w_state_next = r_state;
        w_rr_next    = r_rr;
        w_owner_next = r_owner;
        w_err_next   = r_err;
        w_wdog_next  = r_wdog;
        case (r_state)
            ST_IDLE: begin
                w_wdog_next = '0;
                if (|req) begin
                    w_state_next = ST_ARB;
                    w_owner_next = w_winner;
                end
            end
            ST_ARB: begin
                w_wdog_next  = '0;
                w_state_next = ST_XFER;
            end
            ST_XFER: begin
                if (w_accept) begin
                    w_wdog_next = '0;
                    if (w_own_last) begin
                        w_rr_next    = r_owner;
                        w_state_next = ST_IDLE;
                    end
                end else if (!full && !w_own_req) begin
                    // Owner is silent while the FIFO could take data.
                    if (r_wdog == WD_LIMIT) begin
                        w_err_next   = 1'b1;
                        w_rr_next    = r_owner;
                        w_state_next = ST_IDLE;
                        w_wdog_next  = '0;
                    end else begin
                        w_wdog_next = r_wdog + 8'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any lock at once.
    always_ff @(posedge wclk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_rr    <= IDW'(NREQ - 1);
            r_owner <= '0;
            r_err   <= 1'b0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_next;
            r_rr    <= w_rr_next;
            r_owner <= w_owner_next;
            r_err   <= w_err_next;
            r_wdog  <= w_wdog_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: per-requester beat queues drive the DUTs,
// expected FIFO writes go into scoreboards, and a monitor pops and compares
// on every push. Directed scenarios plus randomized packet mixes.
module tb_fifo_wr_arbiter;

    logic        wclk = 1'b0;
    logic        reset = 1'b1;

    always #5 wclk = ~wclk;

    // 4-requester instance
    logic [3:0]  req4, last4, gnt4;
    logic [31:0] data4;
    logic        push4, full4, busy4, err4;
    logic [7:0]  wdata4;
    logic [1:0]  owner4;

    // 2-requester instance
    logic [1:0]  req2, last2, gnt2;
    logic [15:0] data2;
    logic        push2, full2, busy2, err2;
    logic [7:0]  wdata2;
    logic [0:0]  owner2;

    fifo_wr_arbiter #(.NREQ(4), .IDW(2), .DWIDTH(8), .TIMEOUT(15)) dut4 (
        .wclk(wclk), .reset(reset), .req(req4), .req_last(last4),
        .req_data(data4), .gnt(gnt4), .push(push4), .wdata(wdata4),
        .full(full4), .owner(owner4), .busy(busy4), .err(err4)
    );

    fifo_wr_arbiter #(.NREQ(2), .IDW(1), .DWIDTH(8), .TIMEOUT(15)) dut2 (
        .wclk(wclk), .reset(reset), .req(req2), .req_last(last2),
        .req_data(data2), .gnt(gnt2), .push(push2), .wdata(wdata2),
        .full(full2), .owner(owner2), .busy(busy2), .err(err2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] r;
        logic [7:0] d;
    } exp_t;

    exp_t exp4[$];
    exp_t exp2[$];

    // Requesters 0..3 feed dut4, 4..5 feed dut2 (as its requesters 0..1).
    logic [7:0] bd [6][64];
    logic       bl [6][64];
    int         head [6];
    int         tail [6];
    int         full_mode = 0;   // 0: low, 1: random, 2: driven by main

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, want);
        end
    endtask

    task automatic load(input int i, input logic [7:0] d, input logic l);
        bd[i][tail[i]] = d;
        bl[i][tail[i]] = l;
        tail[i]++;
    endtask

    task automatic ex4(input int r, input logic [7:0] d);
        exp4.push_back('{r: 3'(r), d: d});
    endtask

    task automatic ex2(input int r, input logic [7:0] d);
        exp2.push_back('{r: 3'(r), d: d});
    endtask

    // Round-robin at packet level: every requester with packets left is
    // considered to be requesting; the next packet comes from the first such
    // requester after the previous winner.
    task automatic model(input int base, input int n, input bit is4);
        int pos [6];
        int ptr;
        int found;
        int c;
        logic l;
        for (int i = 0; i < 6; i++) pos[i] = head[i];
        ptr = n - 1;
        forever begin
            found = -1;
            for (int k = 1; k <= n; k++) begin
                c = (ptr + k) % n;
                if (found < 0 && pos[base + c] < tail[base + c]) found = c;
            end
            if (found < 0) break;
            do begin
                if (is4) ex4(found, bd[base + found][pos[base + found]]);
                else     ex2(found, bd[base + found][pos[base + found]]);
                l = bl[base + found][pos[base + found]];
                pos[base + found]++;
            end while (!l);
            ptr = found;
        end
    endtask

    // Requester driver: accepted beats (gnt seen mid-cycle) are retired after
    // the edge; idle lanes drive junk data and random last.
    initial begin
        logic [5:0] gc;
        req4 = '0; last4 = '0; data4 = '0; full4 = 1'b0;
        req2 = '0; last2 = '0; data2 = '0; full2 = 1'b0;
        forever begin
            @(negedge wclk);
            gc = {gnt2, gnt4};
            @(posedge wclk);
            #1;
            for (int i = 0; i < 6; i++)
                if (gc[i] && head[i] < tail[i]) head[i]++;
            for (int i = 0; i < 4; i++) begin
                if (head[i] < tail[i]) begin
                    req4[i] = 1'b1;
                    last4[i] = bl[i][head[i]];
                    data4[i*8 +: 8] = bd[i][head[i]];
                end else begin
                    req4[i] = 1'b0;
                    last4[i] = 1'($urandom % 2);
                    data4[i*8 +: 8] = 8'($urandom);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (head[i+4] < tail[i+4]) begin
                    req2[i] = 1'b1;
                    last2[i] = bl[i+4][head[i+4]];
                    data2[i*8 +: 8] = bd[i+4][head[i+4]];
                end else begin
                    req2[i] = 1'b0;
                    last2[i] = 1'($urandom % 2);
                    data2[i*8 +: 8] = 8'($urandom);
                end
            end
            if (full_mode == 1) begin
                full4 = (($urandom % 4) == 0);
                full2 = (($urandom % 4) == 0);
            end else if (full_mode == 0) begin
                full4 = 1'b0;
                full2 = 1'b0;
            end
        end
    end

    // Monitor: every FIFO write is popped against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge wclk);
            if (push4) begin
                if (exp4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL push4_unexpected actual=%0h required=none", wdata4);
                end else begin
                    e = exp4.pop_front();
                    check("wdata4", wdata4, e.d);
                    check("owner4", owner4, e.r);
                    check("gnt4_onehot", gnt4, 32'd1 << owner4);
                end
            end else begin
                check("gnt4_idle", gnt4, 0);
            end
            if (push2) begin
                if (exp2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL push2_unexpected actual=%0h required=none", wdata2);
                end else begin
                    e = exp2.pop_front();
                    check("wdata2", wdata2, e.d);
                    check("owner2", owner2, e.r);
                    check("gnt2_onehot", gnt2, 32'd1 << owner2);
                end
            end else begin
                check("gnt2_idle", gnt2, 0);
            end
        end
    end

    task automatic do_reset();
        @(posedge wclk);
        #1 reset = 1'b1;
        @(negedge wclk);
        for (int i = 0; i < 6; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        exp4.delete();
        exp2.delete();
        @(negedge wclk);
        reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while ((exp4.size() != 0 || exp2.size() != 0) && b > 0) begin
            @(negedge wclk);
            b--;
        end
        @(negedge wclk);
        check("drain_left", exp4.size() + exp2.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 6; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        reset = 1'b1;
        repeat (3) @(negedge wclk);
        check("rst_busy", busy4, 0);
        check("rst_owner", owner4, 0);
        check("rst_err", err4, 0);
        check("rst_push", push4, 0);
        reset = 1'b0;

        // 3-beat packet from requester 0
        load(0, 8'hA1, 1'b0); load(0, 8'hA2, 1'b0); load(0, 8'hA3, 1'b1);
        ex4(0, 8'hA1); ex4(0, 8'hA2); ex4(0, 8'hA3);
        @(negedge wclk);
        check("t1_busy_c0", busy4, 0);
        @(negedge wclk);
        check("t1_busy_arb", busy4, 1);
        check("t1_push_arb", push4, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge wclk);
            check("t1_push_beat", push4, 1);
        end
        @(negedge wclk);
        check("t1_busy_after", busy4, 0);

        // All four requesting single-beat packets: rotation and spacing
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) load(i, 8'(8'h10 * i), 1'b1);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) ex4(i, 8'(8'h10 * i));
        for (int k = 0; k < 24; k++) begin
            @(negedge wclk);
            check("t2_push_spacing", push4, (k % 3) == 2);
        end
        @(negedge wclk);
        check("t2_busy_end", busy4, 0);

        // Full stalls requester 2 mid-packet; requester 1 waits for beat 4
        do_reset();
        full_mode = 2;
        for (int b = 1; b <= 4; b++) begin
            load(2, 8'(8'h20 + b), b == 4);
            ex4(2, 8'(8'h20 + b));
        end
        repeat (3) @(negedge wclk);
        @(negedge wclk);
        check("t3_beat2", push4, 1);
        load(1, 8'h51, 1'b1);
        ex4(1, 8'h51);
        @(posedge wclk);
        #1 full4 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge wclk);
            check("t3_gnt2_full", gnt4[2], 0);
            check("t3_push_full", push4, 0);
            check("t3_busy_full", busy4, 1);
        end
        @(posedge wclk);
        #1 full4 = 1'b0;
        drain(100);
        check("t3_err", err4, 0);
        full_mode = 0;

        // Watchdog: requester 1 stalls after one beat
        do_reset();
        load(1, 8'h61, 1'b0);
        ex4(1, 8'h61);
        repeat (3) @(negedge wclk);
        check("t4_beat", push4, 1);
        repeat (14) @(negedge wclk);
        @(negedge wclk);
        check("t4_err_before", err4, 0);
        check("t4_busy_before", busy4, 1);
        @(negedge wclk);
        check("t4_err_abort", err4, 1);
        check("t4_busy_abort", busy4, 0);
        load(3, 8'h71, 1'b1);
        load(0, 8'h72, 1'b1);
        ex4(3, 8'h71);
        ex4(0, 8'h72);
        drain(100);
        check("t4_err_sticky", err4, 1);

        // Reset during beat 2 of a 4-beat packet
        do_reset();
        check("t5_err_cleared", err4, 0);
        for (int b = 1; b <= 4; b++) load(2, 8'(8'h80 + b), b == 4);
        ex4(2, 8'h81);
        repeat (3) @(negedge wclk);
        check("t5_beat1", push4, 1);
        @(posedge wclk);
        #1 reset = 1'b1;
        @(negedge wclk);
        check("t5_push_in_reset", push4, 0);
        head[2] = tail[2];
        @(negedge wclk);
        check("t5_push_after", push4, 0);
        check("t5_busy_after", busy4, 0);
        check("t5_owner_after", owner4, 0);
        check("t5_err_after", err4, 0);
        reset = 1'b0;
        load(3, 8'h91, 1'b1);
        load(0, 8'h92, 1'b1);
        ex4(0, 8'h92);
        ex4(3, 8'h91);
        drain(100);

        // Two-requester build, alternating 1- and 2-beat packets
        do_reset();
        load(4, 8'hC1, 1'b1); load(4, 8'hC2, 1'b0); load(4, 8'hC3, 1'b1);
        load(5, 8'hD1, 1'b0); load(5, 8'hD2, 1'b1); load(5, 8'hD3, 1'b1);
        ex2(0, 8'hC1); ex2(1, 8'hD1); ex2(1, 8'hD2);
        ex2(0, 8'hC2); ex2(0, 8'hC3); ex2(1, 8'hD3);
        drain(100);

        // Randomized packet mixes with random FIFO full on both builds
        for (int round = 0; round < 4; round++) begin
            do_reset();
            full_mode = 1;
            for (int i = 0; i < 6; i++) begin
                int npk;
                int len;
                npk = int'($urandom_range(0, 4));
                for (int p = 0; p < npk; p++) begin
                    len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++)
                        load(i, 8'($urandom), b == len - 1);
                end
            end
            model(0, 4, 1'b1);
            model(4, 2, 1'b0);
            drain(3000);
            check("rnd_err4", err4, 0);
            check("rnd_err2", err2, 0);
            full_mode = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
